// File: rtl/issue_queue_ooo.sv
// issue_queue_ooo: out-of-order issue queue between rename/dispatch and execute.
// Holds up to DEPTH renamed instructions. Operand readiness is tracked by snooping
// the writeback tag broadcasts. Each cycle the oldest fully-ready entry is offered
// for issue, where age is the active-list distance from al_head. Entries younger
// than a mispredicted branch can be squashed selectively.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_in_*/o_in_ready     dispatch handshake: payload, rs/rt tags + ready, AL index
//   i_wb_valid/i_wb_tag   writeback tag broadcasts, port p at [p*TAG_W +: TAG_W]
//   i_al_head             active-list head; this is the age reference
//   i_flush_*             squash of entries younger than i_flush_al_idx
//   o_out_*/i_out_ready   issue handshake towards execute
//   o_count               occupied entries

// One queue slot: holds the stored fields and snoops wakeups for its own tags.
module iq_entry #(
  parameter int PAYLOAD_W = 96,
  parameter int TAG_W     = 6,
  parameter int AL_W      = 5,
  parameter int WB_PORTS  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_alloc,
  input  logic                      i_clear,
  input  logic [PAYLOAD_W-1:0]      i_payload,
  input  logic [TAG_W-1:0]          i_rs_tag,
  input  logic                      i_rs_rdy,
  input  logic [TAG_W-1:0]          i_rt_tag,
  input  logic                      i_rt_rdy,
  input  logic [AL_W-1:0]           i_al_idx,
  input  logic [WB_PORTS-1:0]       i_wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0] i_wb_tag,
  output logic                      o_valid,
  output logic                      o_ready,
  output logic [PAYLOAD_W-1:0]      o_payload,
  output logic [TAG_W-1:0]          o_rs_tag,
  output logic [TAG_W-1:0]          o_rt_tag,
  output logic [AL_W-1:0]           o_al_idx
);
  logic                 r_valid, r_rs_rdy, r_rt_rdy;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [TAG_W-1:0]     r_rs_tag, r_rt_tag;
  logic [AL_W-1:0]      r_al_idx;
  logic                 w_rs_hit, w_rt_hit;

  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (i_wb_valid[p]) begin
        if (i_wb_tag[p*TAG_W +: TAG_W] == r_rs_tag) w_rs_hit = 1'b1;
        if (i_wb_tag[p*TAG_W +: TAG_W] == r_rt_tag) w_rt_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     r_valid <= 1'b0;
    else if (i_alloc) r_valid <= 1'b1;
    else if (i_clear) r_valid <= 1'b0;
  end

  // Storage and ready bits are not reset; they only mean anything while r_valid is set.
  always_ff @(posedge i_clk) begin
    if (i_alloc) begin
      r_payload <= i_payload;
      r_rs_tag  <= i_rs_tag;
      r_rt_tag  <= i_rt_tag;
      r_al_idx  <= i_al_idx;
      r_rs_rdy  <= i_rs_rdy;
      r_rt_rdy  <= i_rt_rdy;
    end else begin
      if (w_rs_hit) r_rs_rdy <= 1'b1;
      if (w_rt_hit) r_rt_rdy <= 1'b1;
    end
  end

  assign o_valid   = r_valid;
  assign o_ready   = r_valid & r_rs_rdy & r_rt_rdy;
  assign o_payload = r_payload;
  assign o_rs_tag  = r_rs_tag;
  assign o_rt_tag  = r_rt_tag;
  assign o_al_idx  = r_al_idx;
endmodule

module issue_queue_ooo #(
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 96,
  parameter int TAG_W     = 6,
  parameter int AL_W      = 5,
  parameter int WB_PORTS  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [PAYLOAD_W-1:0]      i_in_payload,
  input  logic [TAG_W-1:0]          i_in_rs_tag,
  input  logic                      i_in_rs_rdy,
  input  logic [TAG_W-1:0]          i_in_rt_tag,
  input  logic                      i_in_rt_rdy,
  input  logic [AL_W-1:0]           i_in_al_idx,
  input  logic [WB_PORTS-1:0]       i_wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0] i_wb_tag,
  input  logic [AL_W-1:0]           i_al_head,
  input  logic                      i_flush_valid,
  input  logic [AL_W-1:0]           i_flush_al_idx,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [PAYLOAD_W-1:0]      o_out_payload,
  output logic [TAG_W-1:0]          o_out_rs_tag,
  output logic [TAG_W-1:0]          o_out_rt_tag,
  output logic [AL_W-1:0]           o_out_al_idx,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [CW-1:0]                      r_count;
  logic [DEPTH-1:0]                   w_valid, w_rdy, w_alloc_vec, w_clear, w_squash;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]    w_payload;
  logic [DEPTH-1:0][TAG_W-1:0]        w_rs_tag, w_rt_tag;
  logic [DEPTH-1:0][AL_W-1:0]         w_al_idx, w_age;
  logic [AL_W-1:0]                    w_flush_age, w_best_age;
  logic [IW-1:0]                      w_free_idx, w_sel_idx;
  logic [CW-1:0]                      w_sq_cnt;
  logic w_in_ready, w_alloc, w_sel_found, w_issue, w_in_rs_rdy, w_in_rt_rdy;

  assign w_in_ready  = i_rst_n & ~i_flush_valid & (r_count < CW'(DEPTH));
  assign w_alloc     = i_in_valid & w_in_ready;
  assign w_flush_age = i_flush_al_idx - i_al_head;

  // Same-cycle bypass: a broadcast coinciding with dispatch must not be lost.
  always_comb begin
    w_in_rs_rdy = i_in_rs_rdy;
    w_in_rt_rdy = i_in_rt_rdy;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (i_wb_valid[p] && i_wb_tag[p*TAG_W +: TAG_W] == i_in_rs_tag) w_in_rs_rdy = 1'b1;
      if (i_wb_valid[p] && i_wb_tag[p*TAG_W +: TAG_W] == i_in_rt_tag) w_in_rt_rdy = 1'b1;
    end
  end

  // Lowest-index free slot; scanning downward leaves the lowest one as the result.
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!w_valid[i]) w_free_idx = IW'(i);
  end

  // Oldest-ready select. al_idx values are unique, so strict < never sees a tie.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_best_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rdy[i] && (!w_sel_found || w_age[i] < w_best_age)) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IW'(i);
        w_best_age  = w_age[i];
      end
    end
  end

  always_comb begin
    w_sq_cnt = '0;
    for (int i = 0; i < DEPTH; i++) w_sq_cnt = w_sq_cnt + CW'(w_squash[i]);
  end

  assign o_out_valid = w_sel_found & ~i_flush_valid & i_rst_n;
  assign w_issue     = o_out_valid & i_out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    // Modular age relative to the AL head keeps wrap-around ordering correct.
    assign w_age[g]       = w_al_idx[g] - i_al_head;
    assign w_squash[g]    = i_flush_valid & w_valid[g] & (w_age[g] > w_flush_age);
    assign w_alloc_vec[g] = w_alloc & (w_free_idx == IW'(g));
    assign w_clear[g]     = w_squash[g] | (w_issue & (w_sel_idx == IW'(g)));

    iq_entry #(
      .PAYLOAD_W(PAYLOAD_W), .TAG_W(TAG_W), .AL_W(AL_W), .WB_PORTS(WB_PORTS)
    ) u_ent (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_alloc   (w_alloc_vec[g]),
      .i_clear   (w_clear[g]),
      .i_payload (i_in_payload),
      .i_rs_tag  (i_in_rs_tag),
      .i_rs_rdy  (w_in_rs_rdy),
      .i_rt_tag  (i_in_rt_tag),
      .i_rt_rdy  (w_in_rt_rdy),
      .i_al_idx  (i_in_al_idx),
      .i_wb_valid(i_wb_valid),
      .i_wb_tag  (i_wb_tag),
      .o_valid   (w_valid[g]),
      .o_ready   (w_rdy[g]),
      .o_payload (w_payload[g]),
      .o_rs_tag  (w_rs_tag[g]),
      .o_rt_tag  (w_rt_tag[g]),
      .o_al_idx  (w_al_idx[g])
    );
  end

  // Flush blocks alloc and issue, so the two count updates never combine.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)           r_count <= '0;
    else if (i_flush_valid) r_count <= r_count - w_sq_cnt;
    else                    r_count <= r_count + CW'(w_alloc) - CW'(w_issue);
  end

  assign o_in_ready    = w_in_ready;
  assign o_count       = r_count;
  assign o_out_payload = w_payload[w_sel_idx];
  assign o_out_rs_tag  = w_rs_tag[w_sel_idx];
  assign o_out_rt_tag  = w_rt_tag[w_sel_idx];
  assign o_out_al_idx  = w_al_idx[w_sel_idx];
endmodule

// File: tb/tb_issue_queue_ooo.sv
// Directed bench for issue_queue_ooo. Inputs change just after the falling edge;
// outputs are checked 1ns later, well away from the rising edge.
module tb_issue_queue_ooo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [95:0] in_payload;
  logic [5:0]  in_rs_tag, in_rt_tag;
  logic        in_rs_rdy, in_rt_rdy;
  logic [4:0]  in_al_idx;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [4:0]  al_head;
  logic        flush_valid;
  logic [4:0]  flush_al_idx;
  logic        out_valid, out_ready;
  logic [95:0] out_payload;
  logic [5:0]  out_rs_tag, out_rt_tag;
  logic [4:0]  out_al_idx;
  logic [4:0]  count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_queue_ooo dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_payload(in_payload),
    .i_in_rs_tag(in_rs_tag), .i_in_rs_rdy(in_rs_rdy),
    .i_in_rt_tag(in_rt_tag), .i_in_rt_rdy(in_rt_rdy), .i_in_al_idx(in_al_idx),
    .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_al_head(al_head),
    .i_flush_valid(flush_valid), .i_flush_al_idx(flush_al_idx),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_payload(out_payload),
    .o_out_rs_tag(out_rs_tag), .o_out_rt_tag(out_rt_tag), .o_out_al_idx(out_al_idx),
    .o_count(count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issued entry must carry the payload it was dispatched with (0x100 + al).
  task automatic chk_out(input string tag, input int al);
    chk({tag, ".valid"}, 128'(out_valid), 128'(1));
    chk({tag, ".al"}, 128'(out_al_idx), 128'(al));
    chk({tag, ".payload"}, 128'(out_payload), 128'(96'h100 + 96'(al)));
  endtask

  task automatic offer(input int al, input int rs_tag, input logic rs_rdy);
    in_valid   = 1'b1;
    in_al_idx  = 5'(al);
    in_payload = 96'h100 + 96'(al);
    in_rs_tag  = 6'(rs_tag);
    in_rs_rdy  = rs_rdy;
    in_rt_tag  = 6'd0;
    in_rt_rdy  = 1'b1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_payload = '0; in_rs_tag = '0; in_rs_rdy = 1'b0;
    in_rt_tag = '0; in_rt_rdy = 1'b0; in_al_idx = '0; wb_valid = '0; wb_tag = '0;
    al_head = '0; flush_valid = 1'b0; flush_al_idx = '0; out_ready = 1'b1;

    // Reset: nothing accepted or issued while rst_n is low
    nxt();
    offer(0, 0, 1'b1);
    #1 chk("rst.in_ready", 128'(in_ready), 128'(0));
    chk("rst.out_valid", 128'(out_valid), 128'(0));
    nxt(); nxt();
    rst_n = 1'b1; in_valid = 1'b0;
    #1 chk("rst.count", 128'(count), 128'(0));
    chk("rst.out_valid_after", 128'(out_valid), 128'(0));
    chk("rst.in_ready_after", 128'(in_ready), 128'(1));
    nxt();

    // 1: three ready entries issue in order 0,1,2; count 3->0
    out_ready = 1'b0;
    offer(0, 0, 1'b1); nxt();
    offer(1, 0, 1'b1); #1 chk("t1.count1", 128'(count), 128'(1)); nxt();
    offer(2, 0, 1'b1); nxt();
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("t1.count3", 128'(count), 128'(3)); chk_out("t1.iss0", 0); nxt();
    #1 chk("t1.count2", 128'(count), 128'(2)); chk_out("t1.iss1", 1); nxt();
    #1 chk("t1.count1b", 128'(count), 128'(1)); chk_out("t1.iss2", 2); nxt();
    #1 chk("t1.count0", 128'(count), 128'(0));
    chk("t1.empty", 128'(out_valid), 128'(0));

    // 2: younger ready entry bypasses a waiting older one; wakeup issues a cycle later
    offer(4, 9, 1'b0); nxt();
    offer(5, 0, 1'b1); #1 chk("t2.none_ready", 128'(out_valid), 128'(0)); nxt();
    in_valid = 1'b0;
    #1 chk_out("t2.iss5", 5); chk("t2.count2", 128'(count), 128'(2)); nxt();
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd9};
    #1 chk("t2.no_zero_cycle", 128'(out_valid), 128'(0));
    chk("t2.count1", 128'(count), 128'(1)); nxt();
    wb_valid = 2'b00;
    #1 chk_out("t2.iss4", 4); nxt();
    #1 chk("t2.count0", 128'(count), 128'(0));

    // 3: fill all 16 entries unready; full blocks dispatch until an issue retires
    for (int i = 0; i < 16; i++) begin
      offer(i, 20 + i, 1'b0); nxt();
    end
    offer(16, 0, 1'b1);
    #1 chk("t3.count16", 128'(count), 128'(16));
    chk("t3.full_ready", 128'(in_ready), 128'(0));
    chk("t3.none_ready", 128'(out_valid), 128'(0));
    in_valid = 1'b0; wb_valid = 2'b01; wb_tag = {6'd0, 6'd25};
    nxt();
    wb_valid = 2'b00;
    #1 chk_out("t3.iss5", 5);
    chk("t3.no_credit", 128'(in_ready), 128'(0)); nxt();
    #1 chk("t3.count15", 128'(count), 128'(15));
    chk("t3.in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b0; nxt();
    rst_n = 1'b1;
    #1 chk("t3.reset_count", 128'(count), 128'(0));

    // 4: AL wrap-around, head=30, order 30,31,0,1
    al_head = 5'd30; out_ready = 1'b0;
    offer(30, 0, 1'b1); nxt();
    offer(31, 0, 1'b1); nxt();
    offer(0, 0, 1'b1); nxt();
    offer(1, 0, 1'b1); nxt();
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("t4.count4", 128'(count), 128'(4)); chk_out("t4.iss30", 30); nxt();
    #1 chk_out("t4.iss31", 31); nxt();
    #1 chk_out("t4.iss0", 0); nxt();
    #1 chk_out("t4.iss1", 1); nxt();
    #1 chk("t4.count0", 128'(count), 128'(0));
    al_head = 5'd0;

    // 5: flush at al 5 squashes 6,7,8; flush cycle blocks alloc and issue
    out_ready = 1'b0;
    for (int a = 3; a <= 8; a++) begin
      offer(a, 0, 1'b1); nxt();
    end
    offer(9, 0, 1'b1); flush_valid = 1'b1; flush_al_idx = 5'd5; out_ready = 1'b1;
    #1 chk("t5.flush_in_ready", 128'(in_ready), 128'(0));
    chk("t5.flush_out_valid", 128'(out_valid), 128'(0));
    chk("t5.count6", 128'(count), 128'(6)); nxt();
    flush_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("t5.count3", 128'(count), 128'(3)); chk_out("t5.sel3", 3); nxt();
    out_ready = 1'b1;
    #1 chk_out("t5.iss3", 3); nxt();
    #1 chk_out("t5.iss4", 4); nxt();
    #1 chk_out("t5.iss5", 5); nxt();
    #1 chk("t5.count0", 128'(count), 128'(0));
    chk("t5.empty", 128'(out_valid), 128'(0));

    // 6: same-cycle bypass on port 1, then reset mid-stream
    offer(7, 12, 1'b0); wb_valid = 2'b10; wb_tag = {6'd12, 6'd0}; nxt();
    in_valid = 1'b0; wb_valid = 2'b00;
    #1 chk_out("t6.bypass_iss7", 7); nxt();
    offer(8, 50, 1'b0); nxt();
    offer(9, 51, 1'b0);
    #1 chk("t6.count1", 128'(count), 128'(1)); nxt();
    rst_n = 1'b0; offer(10, 0, 1'b1);
    #1 chk("t6.rst_in_ready", 128'(in_ready), 128'(0));
    chk("t6.rst_out_valid", 128'(out_valid), 128'(0));
    chk("t6.count2", 128'(count), 128'(2)); nxt();
    rst_n = 1'b1; in_valid = 1'b0;
    #1 chk("t6.reset_count", 128'(count), 128'(0));
    chk("t6.reset_out_valid", 128'(out_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
